status_tx_framer: RTL

Builds fixed-length binary status frames and streams them byte by byte on the TX side of the FT245 simple interface (tx_data_si / tx_valid_si / tx_ready_si), giving the host a return channel alongside the sample path. Frames are sent periodically and on request. Each frame carries a sequence number, FIFO flags, and two interval counters: FIFO underruns and samples consumed by the modulator.

---
 rtl/status_tx_framer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/status_tx_framer.sv
// Periodic / on-request 8-byte status frame generator for the FT245 TX byte stream.
// Frame contents are snapshotted at frame start and held stable until the last byte is accepted.
module status_tx_framer #(
    parameter logic [26:0] PERIOD_CLKS = 27'd128000000,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       sample_read,
    input  logic       underrun,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [26:0] timer_q, timer_d;
    logic        pending_q, pending_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] und_q, und_d;
    logic [15:0] rd_q, rd_d;
    logic [1:0]  snap_flags_q, snap_flags_d;
    logic [15:0] snap_und_q, snap_und_d;
    logic [15:0] snap_rd_q, snap_rd_d;
    logic        tick;
    logic        req;
    logic [7:0]  csum;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic p);
        return (p && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Free-running period timer; a zero period keeps it parked and never ticks.
    always_comb begin
        tick    = 1'b0;
        timer_d = '0;
        if (PERIOD_CLKS != '0) begin
            tick    = (timer_q == PERIOD_CLKS - 27'd1);
            timer_d = tick ? '0 : timer_q + 27'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        seq_d        = seq_q;
        snap_flags_d = snap_flags_q;
        snap_und_d   = snap_und_q;
        snap_rd_d    = snap_rd_q;
        und_d        = sat_inc(und_q, underrun);
        rd_d         = sat_inc(rd_q, sample_read);
        req          = trigger | tick;
        case (state_q)
            S_IDLE: begin
                if (req || pending_q) begin
                    state_d      = S_SEND;
                    idx_d        = '0;
                    pending_d    = 1'b0;
                    snap_flags_d = {fifo_full, fifo_empty};
                    snap_und_d   = und_q;
                    snap_rd_d    = rd_q;
                    // A pulse on the snapshot edge belongs to the new interval.
                    und_d        = {15'd0, underrun};
                    rd_d         = {15'd0, sample_read};
                end
            end
            S_SEND: begin
                if (req) pending_d = 1'b1;
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            seq_q        <= '0;
            und_q        <= '0;
            rd_q         <= '0;
            snap_flags_q <= '0;
            snap_und_q   <= '0;
            snap_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            seq_q        <= seq_d;
            und_q        <= und_d;
            rd_q         <= rd_d;
            snap_flags_q <= snap_flags_d;
            snap_und_q   <= snap_und_d;
            snap_rd_q    <= snap_rd_d;
        end
    end

    assign csum = HEADER ^ seq_q ^ {6'd0, snap_flags_q} ^ snap_und_q[15:8] ^ snap_und_q[7:0]
                ^ snap_rd_q[15:8] ^ snap_rd_q[7:0];

    always_comb begin
        tx_data = '0;
        if (state_q == S_SEND) begin
            case (idx_q)
                3'd0: tx_data = HEADER;
                3'd1: tx_data = seq_q;
                3'd2: tx_data = {6'd0, snap_flags_q};
                3'd3: tx_data = snap_und_q[15:8];
                3'd4: tx_data = snap_und_q[7:0];
                3'd5: tx_data = snap_rd_q[15:8];
                3'd6: tx_data = snap_rd_q[7:0];
                default: tx_data = csum;
            endcase
        end
    end

    assign tx_valid   = (state_q == S_SEND);
    assign busy       = (state_q == S_SEND);
    assign frame_done = tx_valid && tx_ready && (idx_q == 3'd7);

endmodule
